game_round_ctrl: RTL and testbench

//  Round sequencer for the whack-a-mole game. Consumes the divider's 1 Hz square wave,

---
 rtl/game_round_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
//
// Round sequencer for the whack-a-mole game. Sits between clock_divider and the
// game datapath. The 1 Hz square wave from the divider is synchronised and turned
// into a one-cycle second tick, which steps the round through
// IDLE -> COUNTDOWN -> PLAY -> OVER. The block also drives the round timer, the
// game-over flag and the periodic mole-spawn requests.
//
// Optional feature macro: GAME_ROUND_CTRL_PAUSE_EN
//   When defined, the pause_btn input and the paused output exist. A pause_btn
//   rising edge toggles pause in COUNTDOWN/PLAY. While paused, ticks are still
//   output but not counted, spawn requests are suppressed and round_active is low.
//
// Parameters
//   START_CNT   pre-round countdown in seconds (>= 1)
//   ROUND_SECS  round length in seconds (>= 1)
//   SPAWN_SECS  seconds between spawn requests during PLAY (>= 1)
//   TIME_W      width of the count outputs
//
// Ports
//   clk           in   system clock, the only clock
//   rst_n         in   asynchronous active-low reset
//   sec_clk       in   1 Hz square wave, asynchronous to clk
//   start_btn     in   debounced start level, rising edge acts
//   pause_btn     in   debounced pause level, rising edge acts (pause builds only)
//   paused        out  pause flag (pause builds only)
//   state         out  0=IDLE 1=COUNTDOWN 2=PLAY 3=OVER
//   countdown     out  seconds left before PLAY
//   time_left     out  seconds left in the round
//   sec_tick      out  one-cycle pulse per sec_clk rising edge
//   spawn_req     out  one-cycle pulse requesting a new mole
//   round_active  out  high in PLAY while not paused
//   game_over     out  high in OVER
// -----------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int unsigned START_CNT  = 3,
  parameter int unsigned ROUND_SECS = 30,
  parameter int unsigned SPAWN_SECS = 2,
  parameter int unsigned TIME_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_clk,
  input  logic              start_btn,
`ifdef GAME_ROUND_CTRL_PAUSE_EN
  input  logic              pause_btn,
  output logic              paused,
`endif
  output logic [1:0]        state,
  output logic [TIME_W-1:0] countdown,
  output logic [TIME_W-1:0] time_left,
  output logic              sec_tick,
  output logic              spawn_req,
  output logic              round_active,
  output logic              game_over
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StCountdown = 2'd1;
  localparam logic [1:0] StPlay      = 2'd2;
  localparam logic [1:0] StOver      = 2'd3;

  localparam logic [TIME_W-1:0] StartVal = TIME_W'(START_CNT);
  localparam logic [TIME_W-1:0] RoundVal = TIME_W'(ROUND_SECS);
  localparam logic [TIME_W-1:0] SpawnVal = TIME_W'(SPAWN_SECS);
  localparam logic [TIME_W-1:0] One      = TIME_W'(1);
  localparam logic [TIME_W-1:0] Zero     = '0;

  // ---------------------------------------------------------------------------
  // sec_clk synchroniser and rising-edge detector.
  // All three flops reset to 1 so a sec_clk that is already high when reset is
  // released does not produce a spurious tick.
  // ---------------------------------------------------------------------------
  logic sec_sync1_q, sec_sync2_q, sec_prev_q, sec_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_sync1_q <= 1'b1;
      sec_sync2_q <= 1'b1;
      sec_prev_q  <= 1'b1;
      sec_tick_q  <= 1'b0;
    end else begin
      sec_sync1_q <= sec_clk;
      sec_sync2_q <= sec_sync1_q;
      sec_prev_q  <= sec_sync2_q;
      sec_tick_q  <= sec_sync2_q & ~sec_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Start button edge detector (input is already debounced and synchronous).
  // ---------------------------------------------------------------------------
  logic start_prev_q;
  logic start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start_btn;
    end
  end

  assign start_edge = start_btn & ~start_prev_q;

  // ---------------------------------------------------------------------------
  // Pause state. paused_now is the current flag, paused_nxt its next value.
  // ---------------------------------------------------------------------------
  logic       paused_now;
  logic       paused_nxt;
  logic [1:0] state_d;
  logic [1:0] state_q;

`ifdef GAME_ROUND_CTRL_PAUSE_EN
  logic pause_prev_q;
  logic paused_q;
  logic pause_edge;

  assign pause_edge = pause_btn & ~pause_prev_q;

  always_comb begin
    paused_nxt = paused_q;
    if ((state_d == StIdle) || (state_d == StOver)) begin
      paused_nxt = 1'b0;
    end else if (pause_edge && ((state_q == StCountdown) || (state_q == StPlay))) begin
      paused_nxt = ~paused_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= pause_btn;
      paused_q     <= paused_nxt;
    end
  end

  assign paused_now = paused_q;
  assign paused     = paused_q;
`else
  assign paused_now = 1'b0;
  assign paused_nxt = 1'b0;
`endif

  // Only unpaused ticks advance the counters; the tick output itself is never gated.
  logic tick_cnt;
  assign tick_cnt = sec_tick_q & ~paused_now;

  // ---------------------------------------------------------------------------
  // Round FSM and counters
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0] countdown_d, countdown_q;
  logic [TIME_W-1:0] time_left_d, time_left_q;
  logic [TIME_W-1:0] spawn_cnt_d, spawn_cnt_q;
  logic              spawn_pre;

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    time_left_d = time_left_q;
    spawn_cnt_d = spawn_cnt_q;
    spawn_pre   = 1'b0;

    case (state_q)
      StIdle: begin
        countdown_d = StartVal;
        time_left_d = RoundVal;
        spawn_cnt_d = Zero;
        // A coincident tick is deliberately ignored: the transition wins.
        if (start_edge) begin
          state_d = StCountdown;
        end
      end

      StCountdown: begin
        if (tick_cnt) begin
          if (countdown_q <= One) begin
            countdown_d = Zero;
            time_left_d = RoundVal;
            spawn_cnt_d = Zero;
            spawn_pre   = 1'b1;  // first mole appears as soon as play begins
            state_d     = StPlay;
          end else begin
            countdown_d = countdown_q - One;
          end
        end
      end

      StPlay: begin
        if (tick_cnt) begin
          if (time_left_q <= One) begin
            // Last second: end the round without a final spawn.
            time_left_d = Zero;
            state_d     = StOver;
          end else begin
            time_left_d = time_left_q - One;
            if (spawn_cnt_q + One >= SpawnVal) begin
              spawn_cnt_d = Zero;
              spawn_pre   = 1'b1;
            end else begin
              spawn_cnt_d = spawn_cnt_q + One;
            end
          end
        end
      end

      default: begin  // StOver
        time_left_d = Zero;
        if (start_edge) begin
          countdown_d = StartVal;
          time_left_d = RoundVal;
          spawn_cnt_d = Zero;
          state_d     = StCountdown;
        end
      end
    endcase
  end

  // Registered output decode, computed from next-state so outputs align with state.
  logic spawn_req_d, round_active_d, game_over_d;

  always_comb begin
    spawn_req_d    = spawn_pre & ~paused_nxt;
    round_active_d = (state_d == StPlay) & ~paused_nxt;
    game_over_d    = (state_d == StOver);
  end

  logic spawn_req_q, round_active_q, game_over_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      countdown_q    <= StartVal;
      time_left_q    <= RoundVal;
      spawn_cnt_q    <= Zero;
      spawn_req_q    <= 1'b0;
      round_active_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      countdown_q    <= countdown_d;
      time_left_q    <= time_left_d;
      spawn_cnt_q    <= spawn_cnt_d;
      spawn_req_q    <= spawn_req_d;
      round_active_q <= round_active_d;
      game_over_q    <= game_over_d;
    end
  end

  assign state        = state_q;
  assign countdown    = countdown_q;
  assign time_left    = time_left_q;
  assign sec_tick     = sec_tick_q;
  assign spawn_req    = spawn_req_q;
  assign round_active = round_active_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with START_CNT=3, ROUND_SECS=5, SPAWN_SECS=2.
// One simulated second is 20 clk cycles of sec_clk (10 high, 10 low).
module tb_game_round_ctrl;

  localparam int unsigned TimeW = 6;

  logic             clk;
  logic             rst_n;
  logic             sec_clk;
  logic             start_btn;
  logic [1:0]       state;
  logic [TimeW-1:0] countdown;
  logic [TimeW-1:0] time_left;
  logic             sec_tick;
  logic             spawn_req;
  logic             round_active;
  logic             game_over;
`ifdef GAME_ROUND_CTRL_PAUSE_EN
  logic             pause_btn;
  logic             paused;
`endif

  int checks;
  int fails;

  game_round_ctrl #(
    .START_CNT (3),
    .ROUND_SECS(5),
    .SPAWN_SECS(2),
    .TIME_W    (TimeW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sec_clk     (sec_clk),
    .start_btn   (start_btn),
`ifdef GAME_ROUND_CTRL_PAUSE_EN
    .pause_btn   (pause_btn),
    .paused      (paused),
`endif
    .state       (state),
    .countdown   (countdown),
    .time_left   (time_left),
    .sec_tick    (sec_tick),
    .spawn_req   (spawn_req),
    .round_active(round_active),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; return 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full sec_clk period starting with a rising edge; counts ticks and spawns seen.
  task automatic do_second(output int ticks, output int spawns);
    ticks  = 0;
    spawns = 0;
    sec_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) sec_clk = 1'b0;
      @(posedge clk);
      #1;
      if (sec_tick === 1'b1) ticks++;
      if (spawn_req === 1'b1) spawns++;
    end
  endtask

  int tk, sp, cnt;
  int exp_tl[5] = '{4, 3, 2, 1, 0};
  int exp_sp[5] = '{0, 1, 0, 1, 0};

  initial begin
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    sec_clk   = 1'b1;
    start_btn = 1'b0;
`ifdef GAME_ROUND_CTRL_PAUSE_EN
    pause_btn = 1'b0;
`endif

    // 1: reset with sec_clk high, no spurious tick after release
    step(3);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_tick === 1'b1) cnt++;
    end
    check("no_tick_after_release", cnt, 0);
    check("rst_state", state, 0);
    check("rst_countdown", countdown, 3);
    check("rst_time_left", time_left, 5);
    check("rst_spawn", spawn_req, 0);
    check("rst_active", round_active, 0);
    check("rst_over", game_over, 0);
    sec_clk = 1'b0;
    step(10);

    // 2: start, countdown 3,2,1,0, then PLAY with an immediate spawn
    start_btn = 1'b1;
    step(1);
    check("start_to_countdown", state, 1);
    start_btn = 1'b0;
    do_second(tk, sp);
    check("cd_tick", tk, 1);
    check("cd_2", countdown, 2);
    do_second(tk, sp);
    check("cd_1", countdown, 1);
    check("cd_state", state, 1);
    do_second(tk, sp);
    check("cd_0", countdown, 0);
    check("play_state", state, 2);
    check("play_time_left", time_left, 5);
    check("play_entry_spawn", sp, 1);
    check("play_active", round_active, 1);

    // 3: round timer, spawn every 2nd tick, no spawn on the final tick
    for (int s = 0; s < 5; s++) begin
      do_second(tk, sp);
      check($sformatf("play_tl_%0d", s), time_left, exp_tl[s]);
      check($sformatf("play_spawn_%0d", s), sp, exp_sp[s]);
      if (s == 0) begin
        // 4a: start during PLAY is ignored
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(1);
        check("start_ignored_play", state, 2);
      end
    end
    check("over_state", state, 3);
    check("over_flag", game_over, 1);
    check("over_active", round_active, 0);
    do_second(tk, sp);
    check("over_tl_hold", time_left, 0);

    // 4b: start from OVER restarts the countdown
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    check("restart_state", state, 1);
    check("restart_countdown", countdown, 3);
    check("restart_over_clr", game_over, 0);

    // 5b: reset mid-PLAY returns to reset values immediately
    for (int s = 0; s < 4; s++) do_second(tk, sp);
    check("midplay_state", state, 2);
    check("midplay_tl", time_left, 4);
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_countdown", countdown, 3);
    check("arst_time_left", time_left, 5);
    check("arst_active", round_active, 0);
    check("arst_tick", sec_tick, 0);
    check("arst_spawn", spawn_req, 0);
    check("arst_over", game_over, 0);
    step(2);
    rst_n = 1'b1;
    step(5);

    // 5a: start edge in the same cycle as a tick in IDLE
    sec_clk = 1'b1;
    step(3);
    check("coincident_tick", sec_tick, 1);
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    check("coincident_state", state, 1);
    check("coincident_cd", countdown, 3);
    step(6);
    sec_clk = 1'b0;
    step(10);
    check("coincident_cd_hold", countdown, 3);

`ifdef GAME_ROUND_CTRL_PAUSE_EN
    // 6: pause at time_left=3 freezes the timer; a second edge resumes
    for (int s = 0; s < 5; s++) do_second(tk, sp);
    check("pre_pause_tl", time_left, 3);
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    check("paused_flag", paused, 1);
    check("paused_active", round_active, 0);
    cnt = 0;
    for (int s = 0; s < 3; s++) begin
      do_second(tk, sp);
      cnt = cnt + tk;
      check($sformatf("paused_spawn_%0d", s), sp, 0);
    end
    check("paused_ticks_out", cnt, 3);
    check("paused_tl_hold", time_left, 3);
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    check("resume_flag", paused, 0);
    check("resume_active", round_active, 1);
    do_second(tk, sp);
    check("resume_tl", time_left, 2);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
